// File: rtl/mux_arr_scan_reg_if.sv
// mux_arr_scan_reg_if: channel inputs, mode/select and the registered output beat
// with its valid/ready handshake. Optional parity signal out_par exists only when
// MUX_ARR_SCAN_PARITY_EN is defined.
// master = producer/consumer side (drives channels, select, out_ready)
// slave  = the mux block itself
interface mux_arr_scan_reg_if #(
    parameter int unsigned W = 2,
    parameter int unsigned N = 4
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic             mode_i;
    logic [SEL_W-1:0] sel_i;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;
`ifdef MUX_ARR_SCAN_PARITY_EN
    logic             out_par;

    modport master (
        output in_data, in_valid, mode_i, sel_i, out_ready,
        input  out_data, out_ch, out_valid, sel_err, out_par
    );
    modport slave (
        input  in_data, in_valid, mode_i, sel_i, out_ready,
        output out_data, out_ch, out_valid, sel_err, out_par
    );
`else
    modport master (
        output in_data, in_valid, mode_i, sel_i, out_ready,
        input  out_data, out_ch, out_valid, sel_err
    );
    modport slave (
        input  in_data, in_valid, mode_i, sel_i, out_ready,
        output out_data, out_ch, out_valid, sel_err
    );
`endif
endinterface

// File: rtl/mux_arr_scan_reg.sv
// mux_arr_scan_reg: registered N-channel, W-bit mux with manual select or
// round-robin scan (DWELL beats per channel), single output beat with valid/ready.
// Optional feature macro: MUX_ARR_SCAN_PARITY_EN adds out_par = ^out_data,
// registered with the beat.
module mux_arr_scan_reg #(
    parameter int unsigned W     = 2,
    parameter int unsigned N     = 4,
    parameter int unsigned DWELL = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux_arr_scan_reg_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(N);
    localparam int unsigned NP    = 1 << SEL_W;
    localparam int unsigned DW    = $clog2(DWELL) + 1;

    typedef enum logic [0:0] {S_MANUAL, S_SCAN} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] scan_ch_q, scan_ch_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [W-1:0]     out_data_q;
    logic [SEL_W-1:0] out_ch_q;
    logic             out_valid_q;
    logic             sel_err_q;

    logic [SEL_W-1:0] cur_ch;
    logic [SEL_W-1:0] scan_next;
    logic [W-1:0]     cur_data;
    logic [NP-1:0]    valid_pad;
    logic             ch_ok, ch_valid, slot_free, load, sel_bad;

    // Pad valids to the full select range so out-of-range selects index a zero.
    assign valid_pad = NP'(bus.in_valid);
    assign cur_ch    = (state_q == S_SCAN) ? scan_ch_q : bus.sel_i;
    assign ch_ok     = 32'(cur_ch) < N;
    assign ch_valid  = ch_ok && valid_pad[cur_ch];
    assign slot_free = !out_valid_q || bus.out_ready;
    assign load      = slot_free && ch_valid;
    assign sel_bad   = (state_q == S_MANUAL) && !ch_ok;
    assign scan_next = (scan_ch_q == SEL_W'(N - 1)) ? '0 : scan_ch_q + 1'b1;

    // Select the data of the current channel.
    always_comb begin
        cur_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (cur_ch == SEL_W'(k)) begin
                cur_data = bus.in_data[k*W +: W];
            end
        end
    end

    // State follows mode_i; scan counters restart on entry to scan and advance
    // only while the output slot can take a beat.
    always_comb begin
        state_d   = bus.mode_i ? S_SCAN : S_MANUAL;
        scan_ch_d = scan_ch_q;
        dwell_d   = dwell_q;
        unique case (state_q)
            S_MANUAL: begin
                if (state_d == S_SCAN) begin
                    scan_ch_d = '0;
                    dwell_d   = '0;
                end
            end
            S_SCAN: begin
                // Leaving scan keeps the counters untouched.
                if (state_d == S_SCAN && slot_free) begin
                    if (!ch_valid || dwell_q == DW'(DWELL - 1)) begin
                        scan_ch_d = scan_next;
                        dwell_d   = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and scan counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_MANUAL;
            scan_ch_q <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            scan_ch_q <= scan_ch_d;
            dwell_q   <= dwell_d;
        end
    end

    // Output beat register: load when the slot is free, hold everything on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            sel_err_q <= slot_free && sel_bad;
            if (slot_free) begin
                out_valid_q <= load;
                if (load) begin
                    out_data_q <= cur_data;
                    out_ch_q   <= cur_ch;
                end
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;

`ifdef MUX_ARR_SCAN_PARITY_EN
    logic out_par_q;

    // Parity travels with the beat it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else if (load) begin
            out_par_q <= ^cur_data;
        end
    end

    assign bus.out_par = out_par_q;
`endif
endmodule
